// File: rtl/mem_waitstate_ctrl_pkg.sv
// Shared types and wait tables for the bus wait-state controller.
// Also provides MEM_SIZE_* encodings when the core defines are absent.
`ifndef MEM_SIZE_BYTE
`define MEM_SIZE_BYTE 2'b00
`endif
`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif

package mem_waitstate_ctrl_pkg;

  typedef enum logic [3:0] {
    RGN_BIOS,
    RGN_EWRAM,
    RGN_IWRAM,
    RGN_IO,
    RGN_PAL,
    RGN_VRAM,
    RGN_OAM,
    RGN_WS0,
    RGN_WS1,
    RGN_WS2,
    RGN_SRAM,
    RGN_UNMAPPED
  } region_e;

  localparam int WC_SRAM_N = 0;
  localparam int WC_WS0_N  = 2;
  localparam int WC_WS0_S  = 4;
  localparam int WC_WS1_N  = 5;
  localparam int WC_WS1_S  = 7;
  localparam int WC_WS2_N  = 8;
  localparam int WC_WS2_S  = 10;

  function automatic logic [3:0] n_waits(
    input logic [1:0] code
  );
    logic [3:0] w;
    unique case (code)
      2'd0:    w = 4'd4;
      2'd1:    w = 4'd3;
      2'd2:    w = 4'd2;
      default: w = 4'd8;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] s_waits(
    input region_e    rgn,
    input logic       fast
  );
    logic [3:0] w;
    w = 4'd1;
    if (!fast) begin
      unique case (rgn)
        RGN_WS0: w = 4'd2;
        RGN_WS1: w = 4'd4;
        default: w = 4'd8;
      endcase
    end
    return w;
  endfunction

  function automatic logic [2:0] size_bytes(
    input logic [1:0] size
  );
    logic [2:0] b;
    unique case (size)
      `MEM_SIZE_BYTE: b = 3'd1;
      `MEM_SIZE_HALF: b = 3'd2;
      default:        b = 3'd4;
    endcase
    return b;
  endfunction

  function automatic logic is_ws(
    input region_e rgn
  );
    return (rgn == RGN_WS0) ||
           (rgn == RGN_WS1) ||
           (rgn == RGN_WS2);
  endfunction

endpackage

// File: rtl/mem_waitstate_ctrl_ws_decode.sv
// Region decode plus WAITCNT-driven N/S wait lookup.
// Purely combinational; sequential choice is made by the caller.
module ws_decode
  import mem_waitstate_ctrl_pkg::*;
#(
  parameter int EWRAM_WAIT = 2
) (
  input  logic [31:0] addr,
  input  logic [15:0] waitcnt,
  output logic [3:0]  region,
  output logic [3:0]  n_wait,
  output logic [3:0]  s_wait
);

  region_e rgn;
  logic    unused_bits;

  assign unused_bits = ^{addr[23:0], waitcnt[15:11]};
  assign region = rgn;

  always_comb begin
    rgn = RGN_UNMAPPED;
    if (addr[31:28] == 4'h0) begin
      unique case (addr[27:24])
        4'h0:    rgn = RGN_BIOS;
        4'h1:    rgn = RGN_UNMAPPED;
        4'h2:    rgn = RGN_EWRAM;
        4'h3:    rgn = RGN_IWRAM;
        4'h4:    rgn = RGN_IO;
        4'h5:    rgn = RGN_PAL;
        4'h6:    rgn = RGN_VRAM;
        4'h7:    rgn = RGN_OAM;
        4'h8:    rgn = RGN_WS0;
        4'h9:    rgn = RGN_WS0;
        4'hA:    rgn = RGN_WS1;
        4'hB:    rgn = RGN_WS1;
        4'hC:    rgn = RGN_WS2;
        4'hD:    rgn = RGN_WS2;
        default: rgn = RGN_SRAM;
      endcase
    end
  end

  always_comb begin
    n_wait = 4'd0;
    s_wait = 4'd0;
    unique case (rgn)
      RGN_EWRAM: begin
        n_wait = 4'(EWRAM_WAIT);
        s_wait = 4'(EWRAM_WAIT);
      end
      RGN_WS0: begin
        n_wait = n_waits(waitcnt[WC_WS0_N +: 2]);
        s_wait = s_waits(RGN_WS0, waitcnt[WC_WS0_S]);
      end
      RGN_WS1: begin
        n_wait = n_waits(waitcnt[WC_WS1_N +: 2]);
        s_wait = s_waits(RGN_WS1, waitcnt[WC_WS1_S]);
      end
      RGN_WS2: begin
        n_wait = n_waits(waitcnt[WC_WS2_N +: 2]);
        s_wait = s_waits(RGN_WS2, waitcnt[WC_WS2_S]);
      end
      RGN_SRAM: begin
        n_wait = n_waits(waitcnt[WC_SRAM_N +: 2]);
        s_wait = n_wait;
      end
      default: begin
        n_wait = 4'd0;
        s_wait = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/mem_waitstate_ctrl.sv
// Bus wait-state controller: region decode, GBA WAITCNT ROM timing, PAUSE.
// Define ROM_WRITE_ABORT_EN to flag BIOS/ROM writes on abort.
module mem_waitstate_ctrl
  import mem_waitstate_ctrl_pkg::*;
#(
  parameter int          EWRAM_WAIT   = 2,
  parameter logic [31:0] WAITCNT_ADDR = 32'h0400_0204
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        pause,
  output logic        abort,
  output logic        seq,
  output logic [15:0] waitcnt
);

  logic [3:0]  cnt;
  logic        acc;
  logic [3:0]  rgn_raw;
  region_e     rgn;
  logic [3:0]  n_wait;
  logic [3:0]  s_wait;
  logic [3:0]  w;
  logic        is_seq;
  logic [31:0] next_addr;
  logic        prev_vld;
  logic [31:0] prev_addr;
  logic [1:0]  prev_size;
  region_e     prev_rgn;
  logic        wc_sel;
  logic [1:0]  arm_d;
  logic [1:0]  wc_arm;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:15];

  assign acc   = (cnt == 4'd0);
  assign pause = !acc;

  ws_decode #(
    .EWRAM_WAIT(EWRAM_WAIT)
  ) u_ws_decode (
    .addr    (addr),
    .waitcnt (waitcnt),
    .region  (rgn_raw),
    .n_wait  (n_wait),
    .s_wait  (s_wait)
  );

  assign rgn = region_e'(rgn_raw);

  // a 128 KiB boundary always restarts the ROM burst
  assign next_addr = prev_addr + {29'd0, size_bytes(prev_size)};
  assign is_seq = prev_vld &&
                  is_ws(rgn) &&
                  (rgn == prev_rgn) &&
                  (addr == next_addr) &&
                  (addr[16:0] != 17'd0);
  assign w = is_seq ? s_wait : n_wait;

  assign wc_sel = (addr[31:2] == WAITCNT_ADDR[31:2]);

  always_comb begin
    arm_d = 2'b00;
    if (acc && write && wc_sel) begin
      unique case (1'b1)
        (size == `MEM_SIZE_BYTE) &&
        (addr[1:0] == 2'd0): arm_d = 2'b01;
        (size == `MEM_SIZE_BYTE) &&
        (addr[1:0] == 2'd1): arm_d = 2'b10;
        (size != `MEM_SIZE_BYTE) &&
        (addr[1:0] == 2'd0): arm_d = 2'b11;
        default:             arm_d = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      seq       <= 1'b0;
      prev_vld  <= 1'b0;
      prev_addr <= 32'd0;
      prev_size <= 2'd0;
      prev_rgn  <= RGN_UNMAPPED;
      wc_arm    <= 2'b00;
      waitcnt   <= 16'h0000;
    end else begin
      wc_arm <= arm_d;
      if (wc_arm[0]) waitcnt[7:0]  <= wdata[7:0];
      if (wc_arm[1]) waitcnt[15:8] <= {1'b0, wdata[14:8]};
      if (acc) begin
        cnt       <= w;
        seq       <= is_seq;
        prev_vld  <= 1'b1;
        prev_addr <= addr;
        prev_size <= size;
        prev_rgn  <= rgn;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef ROM_WRITE_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort <= 1'b0;
    end else begin
      abort <= acc && write &&
               ((rgn == RGN_BIOS) || is_ws(rgn));
    end
  end
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_mem_waitstate_ctrl.sv
// Scoreboard bench for mem_waitstate_ctrl against a behavioural bus model.
// Honours ROM_WRITE_ABORT_EN when it is defined for the build.
`ifndef MEM_SIZE_BYTE
`define MEM_SIZE_BYTE 2'b00
`endif
`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif

module tb_mem_waitstate_ctrl;

  localparam logic [31:0] WC_ADDR = 32'h0400_0204;
`ifdef ROM_WRITE_ABORT_EN
  localparam int ABORT_EXP = 1;
`else
  localparam int ABORT_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [1:0]  size = `MEM_SIZE_WORD;
  logic        write = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        pause;
  logic        abort;
  logic        seq;
  logic [15:0] waitcnt;

  mem_waitstate_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .size    (size),
    .write   (write),
    .wdata   (wdata),
    .pause   (pause),
    .abort   (abort),
    .seq     (seq),
    .waitcnt (waitcnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    int          w;
    int          s;
    int          ab;
    int          wc;
    int          cw;
    int          cs;
    int          ca;
    logic [31:0] a;
  } exp_t;

  exp_t exp_q[$];

  // behavioural model of the bus rules
  int ntab[4]   = '{4, 3, 2, 8};
  int sfirst[3] = '{2, 4, 8};
  int nlo[3]    = '{2, 5, 8};
  int slo[3]    = '{4, 7, 10};

  logic [15:0] m_wc;
  bit          m_pend;
  logic [1:0]  m_qsz;
  logic [1:0]  m_qoff;
  logic [31:0] m_qwd;
  bit          m_pv;
  logic [31:0] m_pa;
  logic [1:0]  m_psz;
  int          m_pk;

  function automatic void model_reset();
    m_wc = 16'h0000;
    m_pend = 0;
    m_pv = 0;
    m_pa = 32'd0;
    m_psz = 2'd0;
    m_pk = -2;
  endfunction

  function automatic int ws_idx(logic [31:0] a);
    int nib;
    nib = int'(a[27:24]);
    if (a[31:28] != 4'h0) return -2;
    if (nib >= 8 && nib <= 13) return (nib - 8) / 2;
    return -1;
  endfunction

  task automatic model_step(
    input logic [31:0] a, input logic [1:0] sz,
    input logic wr, input logic [31:0] wd,
    output exp_t e
  );
    int  nib;
    int  k;
    bit  mapped;
    bit  sq;
    int  w;
    nib = int'(a[27:24]);
    mapped = (a[31:28] == 4'h0);
    k = ws_idx(a);
    sq = 0;
    w = 0;
    if (mapped && nib == 2) w = 2;
    else if (k >= 0) begin
      sq = m_pv && (m_pk == k) &&
           (a == m_pa + (32'd1 << m_psz)) &&
           (a[16:0] != 17'd0);
      if (sq) w = m_wc[slo[k]] ? 1 : sfirst[k];
      else w = ntab[m_wc[nlo[k] +: 2]];
    end else if (mapped && nib >= 14) w = ntab[m_wc[1:0]];
    e.w = w;
    e.s = int'(sq);
    e.ab = (ABORT_EXP == 1 && wr && mapped &&
            (nib == 0 || k >= 0)) ? 1 : 0;
    e.wc = int'(m_wc);
    e.a = a;
    m_pv = 1;
    m_pa = a;
    m_psz = sz;
    m_pk = k;
    // a pending update lands after the following access was costed
    if (m_pend) begin
      if (m_qsz == `MEM_SIZE_BYTE) begin
        if (m_qoff == 2'd0) m_wc[7:0] = m_qwd[7:0];
        else if (m_qoff == 2'd1) m_wc[15:8] = m_qwd[15:8];
      end else if (m_qoff == 2'd0) m_wc = m_qwd[15:0];
      m_wc[15] = 1'b0;
      m_pend = 0;
    end
    if (wr && a[31:2] == WC_ADDR[31:2]) begin
      m_pend = 1;
      m_qsz = sz;
      m_qoff = a[1:0];
      m_qwd = wd;
    end
  endtask

  logic [31:0] last_a = 32'd0;
  logic [1:0]  last_sz = 2'd2;

  task automatic issue(
    input logic [31:0] a, input logic [1:0] sz,
    input logic wr, input logic [31:0] wd,
    input int cw = -1, input int cs = -1, input int ca = -1
  );
    exp_t e;
    int   g;
    g = 0;
    while (pause && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) chk("stall_bound", int'(pause), 0);
    addr = a;
    size = sz;
    write = wr;
    model_step(a, sz, wr, wd, e);
    e.cw = cw;
    e.cs = cs;
    e.ca = ca;
    exp_q.push_back(e);
    last_a = a;
    last_sz = sz;
    @(negedge clk);
    wdata = wd;
  endtask

  // monitor: measures every address cycle independently of the driver
  bit          mon_en = 0;
  bit          draining = 0;
  bit          active = 0;
  bit          prev_pause = 0;
  logic [15:0] prev_wc = 16'h0;
  exp_t        cur;
  int          wobs;
  int          seq_obs;
  int          ab_obs;
  int          wc_obs;

  task automatic finish_cur();
    chk($sformatf("waits@%h", cur.a), wobs, cur.w);
    chk($sformatf("seq@%h", cur.a), seq_obs, cur.s);
    chk($sformatf("abort@%h", cur.a), ab_obs, cur.ab);
    chk($sformatf("wc_used@%h", cur.a), wc_obs, cur.wc);
    if (cur.cw >= 0) chk("plan_waits", wobs, cur.cw);
    if (cur.cs >= 0) chk("plan_seq", seq_obs, cur.cs);
    if (cur.ca >= 0) chk("plan_abort", ab_obs, cur.ca);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n) begin
      if (!prev_pause) begin
        if (active) finish_cur();
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          active = 1;
          wobs = int'(pause);
          seq_obs = int'(seq);
          ab_obs = int'(abort);
          wc_obs = int'(prev_wc);
        end else begin
          active = 0;
          if (!draining) chk("unexpected_access", 1, 0);
        end
      end else if (active) begin
        wobs += int'(pause);
        if (wobs > 12) begin
          chk("pause_bound", wobs, cur.w);
          active = 0;
        end
      end
    end else begin
      active = 0;
    end
    prev_pause = pause;
    prev_wc = waitcnt;
  end

  task automatic rand_access();
    int          r;
    int          nib;
    logic [1:0]  sz;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    r = $urandom_range(0, 11);
    sz = 2'($urandom_range(0, 2));
    wr = ($urandom_range(0, 5) == 0);
    wd = $urandom;
    a = 32'h0300_0000;
    case (r)
      0, 1: begin
        a = {WC_ADDR[31:2], 2'($urandom_range(0, 3))};
        wr = 1'b1;
      end
      2, 3, 4, 5: begin
        a = last_a + (32'd1 << last_sz);
        sz = last_sz;
      end
      6: begin
        nib = $urandom_range(8, 13);
        a = {4'h0, 4'(nib), 7'($urandom), 17'h1FFFC};
        sz = `MEM_SIZE_WORD;
      end
      7: a = {4'h0, 4'($urandom_range(0, 15)), 22'($urandom), 2'b00};
      8: a = {4'($urandom_range(1, 15)), 28'($urandom)};
      9: a = {4'h0, 4'($urandom_range(8, 13)), 14'($urandom), 10'd0};
      10: begin
        nib = ($urandom_range(0, 2) == 0) ? 2 : $urandom_range(14, 15);
        a = {4'h0, 4'(nib), 22'($urandom), 2'b00};
      end
      default: a = 32'h0300_0000;
    endcase
    issue(a, sz, wr, wd);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pause", int'(pause), 0);
    chk("rst_seq", int'(seq), 0);
    chk("rst_abort", int'(abort), 0);
    chk("rst_waitcnt", int'(waitcnt), 0);
    rst_n = 1'b1;
    mon_en = 1;

    issue(32'h0300_0000, `MEM_SIZE_WORD, 0, 0, 0, 0, 0);
    issue(32'h0200_0000, `MEM_SIZE_WORD, 0, 0, 2, 0, 0);
    issue(32'h0800_0000, `MEM_SIZE_WORD, 0, 0, 4, 0, 0);
    issue(32'h0800_0004, `MEM_SIZE_WORD, 0, 0, 2, 1, 0);

    issue(WC_ADDR, `MEM_SIZE_HALF, 1, 32'h0000_0018, 0, 0, 0);
    issue(32'h0300_0000, `MEM_SIZE_WORD, 0, 0);
    issue(32'h0800_0000, `MEM_SIZE_WORD, 0, 0, 2, 0, 0);
    issue(32'h0800_0004, `MEM_SIZE_WORD, 0, 0, 1, 1, 0);
    chk("waitcnt_0018", int'(waitcnt), 16'h0018);

    issue(WC_ADDR, `MEM_SIZE_HALF, 1, 32'h0000_0000);
    issue(32'h0300_0000, `MEM_SIZE_WORD, 0, 0);
    issue(32'h0C01_FFFC, `MEM_SIZE_WORD, 0, 0, 4, 0, 0);
    issue(32'h0C02_0000, `MEM_SIZE_WORD, 0, 0, 4, 0, 0);
    issue(32'h0800_0010, `MEM_SIZE_WORD, 1, 32'hDEAD_BEEF, 4, 0, ABORT_EXP);
    issue(32'h0300_0000, `MEM_SIZE_WORD, 0, 0, 0, 0, 0);

    draining = 1;
    repeat (15) @(negedge clk);
    mon_en = 0;
    draining = 0;
    issue(WC_ADDR + 32'd1, `MEM_SIZE_BYTE, 1, 32'h0000_0300);
    issue(32'h0300_0000, `MEM_SIZE_WORD, 0, 0);
    issue(32'h0C00_0000, `MEM_SIZE_WORD, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_cycle3", int'(pause), 1);
    chk("waitcnt_0300", int'(waitcnt), 16'h0300);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pause", int'(pause), 0);
    chk("async_rst_waitcnt", int'(waitcnt), 0);
    chk("async_rst_seq", int'(seq), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    mon_en = 1;
    issue(32'h0C00_0004, `MEM_SIZE_WORD, 0, 0, 4, 0, 0);

    for (int i = 0; i < 400; i++) rand_access();

    draining = 1;
    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
